// File: rtl/iiitb_lifo_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iiitb_lifo_ctrl_if : request/response handshake bundle for the LIFO ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
interface iiitb_lifo_ctrl_if #(
  parameter int DATA_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/iiitb_lifo_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iiitb_lifo_ctrl : sequences push/pop requests onto an external stack and
//                   returns one response per request, tracking occupancy.
// Rev 1.0
// ---------------------------------------------------------------------------
module iiitb_lifo_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   Rst,
  iiitb_lifo_ctrl_if.slave       bus,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   desync,
  output logic [3:0]             lifo_din,
  output logic                   lifo_rw,
  output logic                   lifo_en,
  output logic                   lifo_rst,
  input  logic [3:0]             lifo_dout,
  input  logic                   lifo_empty,
  input  logic                   lifo_full
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    ISSUE = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_op;
  logic [3:0]       r_data;
  logic [CNT_W-1:0] r_depth;
  logic [3:0]       r_rsp_data;
  logic             r_rsp_err;
  logic             r_desync;

  logic             w_req_ready;
  logic             w_rsp_valid;
  logic             w_accept;
  logic             w_reject;
  logic             w_flag_mismatch;

  // Overflow/underflow is judged on the incoming op, before it is latched.
  assign w_reject = bus.req_op ? (r_depth == '0) : (r_depth == c_full);

  // Depth has already moved on the ISSUE edge, so it matches post-op flags.
  assign w_flag_mismatch = (lifo_empty != (r_depth == '0)) ||
                           (lifo_full  != (r_depth == c_full));

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_state <= INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    w_accept     = 1'b0;
    lifo_en      = 1'b0;
    lifo_rst     = 1'b0;
    lifo_rw      = 1'b0;
    lifo_din     = 4'd0;
    case (r_state)
      INIT: begin
        lifo_en      = 1'b1;
        lifo_rst     = 1'b1;
        w_next_state = IDLE;
      end
      IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          w_next_state = w_reject ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        lifo_en      = 1'b1;
        lifo_rw      = r_op;
        lifo_din     = r_data;
        w_next_state = CAPT;
      end
      CAPT: begin
        w_next_state = RESP;
      end
      RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_op       <= 1'b0;
      r_data     <= 4'd0;
      r_depth    <= '0;
      r_rsp_data <= 4'd0;
      r_rsp_err  <= 1'b0;
      r_desync   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= bus.req_op;
        r_data <= bus.req_data;
        if (w_reject) begin
          r_rsp_data <= 4'd0;
          r_rsp_err  <= 1'b1;
        end
      end
      if (r_state == ISSUE) begin
        r_depth <= r_op ? (r_depth - c_one) : (r_depth + c_one);
      end
      if (r_state == CAPT) begin
        r_rsp_data <= r_op ? lifo_dout : 4'd0;
        r_rsp_err  <= 1'b0;
        if (w_flag_mismatch) begin
          r_desync <= 1'b1;
        end
      end
      // Clear the response once consumed so stale pop data never lingers.
      if ((r_state == RESP) && bus.rsp_ready) begin
        r_rsp_data <= 4'd0;
        r_rsp_err  <= 1'b0;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign depth         = r_depth;
  assign desync        = r_desync;

endmodule
`default_nettype wire

// File: doc/iiitb_lifo_ctrl.md
IIITB_LIFO_CTRL -- requirements
Module: iiitb_lifo_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk is the single clock, and Rst is an asynchronous, active-high reset.
REQ-002 Parameter: DEPTH, default 4, stack capacity in entries; the occupancy counter SHALL be $clog2(DEPTH)+1 bits wide.
REQ-003 Port: clk  in  1  rising-edge clock for all state.
REQ-004 Port: Rst  in  1  reset; forces state INIT and clears all registers.
REQ-005 Port: req_valid  in  1  request present.
REQ-006 Port: req_ready  out  1  request may be accepted this cycle.
REQ-007 Port: req_op  in  1  0 = push, 1 = pop.
REQ-008 Port: req_data  in  4  push data.
REQ-009 Port: rsp_valid  out  1  response present.
REQ-010 Port: rsp_ready  in  1  response consumed.
REQ-011 Port: rsp_data  out  4  popped data; 0 for push or error.
REQ-012 Port: rsp_err  out  1  request rejected (overflow or underflow).
REQ-013 Port: depth  out  3  current occupancy count.
REQ-014 Port: desync  out  1  sticky flag-mismatch indicator.
REQ-015 Port: lifo_din  out  4  data to stack.
REQ-016 Port: lifo_rw  out  1  0 = push, 1 = pop.
REQ-017 Port: lifo_en  out  1  stack enable.
REQ-018 Port: lifo_rst  out  1  stack synchronous clear.
REQ-019 Port: lifo_dout  in  4  registered stack read data.
REQ-020 Port: lifo_empty  in  1  stack empty flag.
REQ-021 Port: lifo_full  in  1  stack full flag.

Function
REQ-022 The FSM SHALL have the states INIT, IDLE, ISSUE, CAPT and RESP, all encoded in one registered state variable.
REQ-023 INIT: the block SHALL drive lifo_en=1 and lifo_rst=1, then move to IDLE on the next edge with Rst low; the stack clears only when its enable is high.
REQ-024 IDLE: the block SHALL drive req_ready=1; an accept occurs when req_valid && req_ready, and on accept the block SHALL latch req_op and req_data.
REQ-025 Accept of a push with depth==DEPTH, or of a pop with depth==0, SHALL go to RESP with rsp_err=1 and rsp_data=0, without a lifo_en pulse and without a depth change.
REQ-026 Any other accept SHALL go to ISSUE.
REQ-027 ISSUE (exactly 1 cycle): the block SHALL drive lifo_en=1, lifo_rst=0, lifo_rw=latched op and lifo_din=latched data, then go to CAPT.
REQ-028 On the ISSUE edge, depth SHALL update: push adds 1, pop subtracts 1.
REQ-029 CAPT (exactly 1 cycle): for a pop, rsp_data SHALL register lifo_dout; for a push, rsp_data SHALL be 0. rsp_err SHALL be 0. The next state SHALL be RESP.
REQ-030 CAPT SHALL also compare flags: if lifo_empty != (depth==0) or lifo_full != (depth==DEPTH), desync SHALL set and stay set until Rst.
REQ-031 RESP: the block SHALL hold rsp_valid=1 with rsp_data and rsp_err stable until rsp_ready=1, then go to IDLE.
REQ-032 A new request SHALL NOT be accepted in the same cycle a response is consumed.
REQ-033 Outside ISSUE and INIT, lifo_en, lifo_rst, lifo_rw and lifo_din SHALL all be 0.
REQ-034 req_ready SHALL be 0 in every state except IDLE.
REQ-035 Latency: for a valid op, rsp_valid SHALL rise 3 cycles after the accept edge; for a rejected op, 1 cycle after it.
REQ-036 Throughput SHALL be at most one request per 4 cycles (valid op) and per 2 cycles (rejected op).
REQ-037 depth SHALL never wrap: it is bounded to 0..DEPTH by REQ-025.
REQ-038 req_op and req_data SHALL be ignored whenever no accept occurs.

Reset
REQ-039 Rst assertion SHALL take effect immediately, independent of clk, from any state, including mid-ISSUE; state SHALL become INIT.
REQ-040 While Rst is high and in the first cycle after release: lifo_en=1, lifo_rst=1, and all other outputs 0 (req_ready, rsp_valid, rsp_data, rsp_err, depth, desync, lifo_rw, lifo_din).
REQ-041 A response pending at reset SHALL be discarded.

Verification
REQ-042 Release Rst, hold req_valid=1 (push, data 0xA) -> lifo_en=lifo_rst=1 for one cycle; accept on the 2nd edge; ISSUE drives din=0xA, rw=0; rsp_valid 3 cycles later with rsp_data=0, err=0, depth=1.
REQ-043 Push 1,2,3,4, then pop x4 against a behavioural 4-deep stack model -> rsp_data=4,3,2,1; depth returns to 0; desync=0.
REQ-044 Push 5 times -> fifth response has rsp_err=1, no lifo_en pulse, depth stays 4.
REQ-045 Pop from empty after reset -> rsp_err=1 and rsp_data=0 one cycle after accept; depth=0.
REQ-046 Hold rsp_ready=0 for 10 cycles during RESP -> rsp outputs stable, req_ready=0, no lifo_en activity; then rsp_ready=1 returns the FSM to IDLE.
REQ-047 Assert Rst during ISSUE -> outputs at reset values asynchronously; after release, INIT pulse occurs; model forces lifo_full=1 with depth=0 in CAPT -> desync=1, held until the next Rst.
